// File: rtl/fpu_pkg.sv
// Shared types for the FPU arbiter slice: status codes, arbiter states and
// the datapath word width.
package fpu_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [3:0] {
      ST_EXACT     = 4'b0001,
      ST_INEXACT   = 4'b0010,
      ST_OVERFLOW  = 4'b0100,
      ST_UNDERFLOW = 4'b1000
   } fpu_status_e;

   // Status reported when the core never answered.
   localparam logic [3:0] ST_TIMEOUT = 4'b0000;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ISSUE   = 2'd1,
      ARB_WAIT    = 2'd2,
      ARB_RESPOND = 2'd3
   } arb_state_e;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester-side bus of the FPU arbiter: request handshake, packed operands,
// response handshake and the shared result/status word.
//   master : client side (drives requests, takes responses)
//   slave  : arbiter side
interface fpu_arbiter_if #(
   parameter int NUM_REQ = 4
);
   import fpu_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*WORD_W-1:0] req_op_a;
   logic [NUM_REQ*WORD_W-1:0] req_op_b;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_ready;
   logic [WORD_W-1:0]         rsp_data;
   logic [3:0]                rsp_status;

   modport master (
      output req_valid, req_op_a, req_op_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_status
   );

   modport slave (
      input  req_valid, req_op_a, req_op_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_status
   );

endinterface

// File: rtl/fpu_rr_pick.sv
// Combinational round-robin picker: first valid index at or above rr_ptr,
// wrapping modulo NUM_REQ. Ports: req_valid, rr_ptr in; any_valid, pick out.
module fpu_rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IW-1:0]      rr_ptr,
   output logic               any_valid,
   output logic [IW-1:0]      pick
);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   // Walk offsets from the far end so the nearest valid slot wins last.
   always_comb begin
      any_valid = |req_valid;
      pick      = '0;
      sum       = '0;
      idx       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(NUM_REQ))
            sum = sum - (IW+1)'(NUM_REQ);
         idx = sum[IW-1:0];
         if (req_valid[idx])
            pick = idx;
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU adder core between NUM_REQ clients.
// Ports: clock100KHz, reset (async, active-high); bus (fpu_arbiter_if.slave)
// carrying request/response handshakes; fpu_start/fpu_op_a/fpu_op_b to the
// core; fpu_done/fpu_result/fpu_status from the core; busy; grant_id.
// Build option: FPU_ARB_TIMEOUT_EN adds a TIMEOUT-cycle watchdog on WAIT.
module fpu_arbiter
   import fpu_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int TIMEOUT = 64,
   localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
   input  logic              clock100KHz,
   input  logic              reset,
   fpu_arbiter_if.slave      bus,
   output logic              fpu_start,
   output logic [WORD_W-1:0] fpu_op_a,
   output logic [WORD_W-1:0] fpu_op_b,
   input  logic              fpu_done,
   input  logic [WORD_W-1:0] fpu_result,
   input  logic [3:0]        fpu_status,
   output logic              busy,
   output logic [IW-1:0]     grant_id
);

   localparam logic [1:0] S_IDLE    = ARB_IDLE;
   localparam logic [1:0] S_ISSUE   = ARB_ISSUE;
   localparam logic [1:0] S_WAIT    = ARB_WAIT;
   localparam logic [1:0] S_RESPOND = ARB_RESPOND;

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   logic [1:0]        state;
   logic [IW-1:0]     rr_ptr;
   logic [IW-1:0]     pick;
   logic [IW-1:0]     next_ptr;
   logic              any_valid;
   logic              accept;
   logic              rsp_take;
   logic              timed_out;
   logic [WORD_W-1:0] rsp_data_q;
   logic [3:0]        rsp_status_q;

   fpu_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_valid (bus.req_valid),
      .rr_ptr    (rr_ptr),
      .any_valid (any_valid),
      .pick      (pick)
   );

   assign accept    = (state == S_IDLE) && any_valid;
   assign rsp_take  = (state == S_RESPOND) && bus.rsp_ready[grant_id];
   assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ?
                      '0 : grant_id + 1'b1;

   assign bus.req_ready  = accept ? (ONE << pick) : '0;
   assign bus.rsp_valid  = (state == S_RESPOND) ?
                           (ONE << grant_id) : '0;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_status = rsp_status_q;

   assign fpu_start = (state == S_ISSUE);
   assign busy      = (state != S_IDLE);

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wait_cnt;

   // wait_cnt holds the number of WAIT cycles already spent, so the
   // TIMEOUT-th WAIT cycle is the one where it equals TIMEOUT-1.
   assign timed_out = (state == S_WAIT) &&
                      (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clock100KHz or posedge reset) begin
      if (reset)
         wait_cnt <= '0;
      else if (state == S_ISSUE)
         wait_cnt <= '0;
      else if (state == S_WAIT)
         wait_cnt <= wait_cnt + 1'b1;
   end
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clock100KHz or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         grant_id     <= '0;
         fpu_op_a     <= '0;
         fpu_op_b     <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  fpu_op_a <= bus.req_op_a[int'(pick)*WORD_W +: WORD_W];
                  fpu_op_b <= bus.req_op_b[int'(pick)*WORD_W +: WORD_W];
                  grant_id <= pick;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               // A real answer beats the watchdog in the same cycle.
               if (fpu_done) begin
                  rsp_data_q   <= fpu_result;
                  rsp_status_q <= fpu_status;
                  state        <= S_RESPOND;
               end else if (timed_out) begin
                  rsp_data_q   <= '0;
                  rsp_status_q <= ST_TIMEOUT;
                  state        <= S_RESPOND;
               end
            end
            S_RESPOND: begin
               if (rsp_take) begin
                  rr_ptr <= next_ptr;
                  state  <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed self-checking bench for fpu_arbiter (NUM_REQ=4, TIMEOUT=8).
// Watchdog scenarios run only when FPU_ARB_TIMEOUT_EN is defined.
module tb_fpu_arbiter;

   logic        clock100KHz = 1'b0;
   logic        reset;
   logic        fpu_start;
   logic [31:0] fpu_op_a;
   logic [31:0] fpu_op_b;
   logic        fpu_done;
   logic [31:0] fpu_result;
   logic [3:0]  fpu_status;
   logic        busy;
   logic [1:0]  grant_id;

   int n_tests = 0;
   int n_fail  = 0;

   fpu_arbiter_if #(.NUM_REQ(4)) bus ();

   fpu_arbiter #(
      .NUM_REQ (4),
      .TIMEOUT (8)
   ) dut (
      .clock100KHz (clock100KHz),
      .reset       (reset),
      .bus         (bus),
      .fpu_start   (fpu_start),
      .fpu_op_a    (fpu_op_a),
      .fpu_op_b    (fpu_op_b),
      .fpu_done    (fpu_done),
      .fpu_result  (fpu_result),
      .fpu_status  (fpu_status),
      .busy        (busy),
      .grant_id    (grant_id)
   );

   always #5 clock100KHz = ~clock100KHz;

   task automatic tick;
      @(posedge clock100KHz);
      #1;
   endtask

   task automatic apply_reset;
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      fpu_done      = 1'b0;
      tick;
      tick;
      reset = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      bus.req_op_a  = '0;
      bus.req_op_b  = '0;
      fpu_done      = 1'b0;
      fpu_result    = '0;
      fpu_status    = '0;
      tick;
      n_tests++;
      if ({bus.req_ready, bus.rsp_valid} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_handshake: got %b/%b want 0000/0000",
                  bus.req_ready, bus.rsp_valid);
      end
      n_tests++;
      if ({bus.rsp_data, bus.rsp_status} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_rsp: got %h/%b want 0/0000",
                  bus.rsp_data, bus.rsp_status);
      end
      n_tests++;
      if ({fpu_start, fpu_op_a, fpu_op_b} !== 65'h0) begin
         n_fail++;
         $display("FAIL reset_core: got %b %h %h want 0 0 0",
                  fpu_start, fpu_op_a, fpu_op_b);
      end
      n_tests++;
      if ({busy, grant_id} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_busy_gid: got %b %0d want 0 0",
                  busy, grant_id);
      end
      reset = 1'b0;
      tick;
      fpu_done   = 1'b1;
      fpu_result = 32'hCAFE_F00D;
      fpu_status = 4'b0001;
      tick;
      fpu_done = 1'b0;
      tick;
      n_tests++;
      if ({busy, bus.rsp_valid, bus.rsp_data} !== 37'h0) begin
         n_fail++;
         $display("FAIL idle_stray_done: got %b %b %h want 0 0000 0",
                  busy, bus.rsp_valid, bus.rsp_data);
      end
   endtask

   task automatic test_single;
      apply_reset;
      bus.req_op_a         = '0;
      bus.req_op_b         = '0;
      bus.req_op_a[95:64]  = 32'h4000_0000;
      bus.req_op_b[95:64]  = 32'h4000_0000;
      bus.req_valid        = 4'b0100;
      #1;
      n_tests++;
      if (bus.req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_ready: got %b want 0100", bus.req_ready);
      end
      tick;
      bus.req_valid = '0;
      n_tests++;
      if ({fpu_start, grant_id, fpu_op_a, fpu_op_b} !==
          {1'b1, 2'd2, 32'h4000_0000, 32'h4000_0000}) begin
         n_fail++;
         $display("FAIL single_issue: got %b %0d %h %h want 1 2 40000000 40000000",
                  fpu_start, grant_id, fpu_op_a, fpu_op_b);
      end
      tick;
      n_tests++;
      if ({fpu_start, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL single_start_pulse: got start=%b busy=%b want 0 1",
                  fpu_start, busy);
      end
      tick;
      tick;
      fpu_done   = 1'b1;
      fpu_result = 32'h4100_0000;
      fpu_status = 4'b0001;
      n_tests++;
      if (bus.rsp_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_early_rsp: got %b want 0000", bus.rsp_valid);
      end
      tick;
      fpu_done = 1'b0;
      n_tests++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status, grant_id} !==
          {4'b0100, 32'h4100_0000, 4'b0001, 2'd2}) begin
         n_fail++;
         $display("FAIL single_rsp: got %b %h %b %0d want 0100 41000000 0001 2",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_status, grant_id);
      end
      bus.rsp_ready = 4'b1011;
      tick;
      n_tests++;
      if (bus.rsp_valid !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_wrong_ready: got %b want 0100", bus.rsp_valid);
      end
      bus.rsp_ready = 4'b0100;
      tick;
      bus.rsp_ready = '0;
      n_tests++;
      if ({bus.rsp_valid, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL single_done: got %b busy=%b want 0000 0",
                  bus.rsp_valid, busy);
      end
   endtask

   task automatic test_back_to_back;
      int exp_g[6] = '{0, 1, 2, 3, 0, 1};
      int gid[6];
      int gcyc[6];
      int ng   = 0;
      int pend = 0;
      int last = 0;
      logic [31:0] want;
      apply_reset;
      for (int i = 0; i < 4; i++) begin
         bus.req_op_a[i*32 +: 32] = 32'h3F80_0000 + 32'(i);
         bus.req_op_b[i*32 +: 32] = 32'h4000_0000 + 32'(i);
      end
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 4'b1111;
      for (int c = 0; c < 60 && ng < 6; c++) begin
         fpu_done   = (pend != 0);
         fpu_result = 32'h1000_0000 + 32'(c);
         fpu_status = 4'b0010;
         pend       = fpu_start ? 1 : 0;
         if (fpu_start) begin
            want = 32'h3F80_0000 + 32'(last);
            n_tests++;
            if (fpu_op_a !== want) begin
               n_fail++;
               $display("FAIL rr_operand: got %h want %h", fpu_op_a, want);
            end
         end
         #1;
         if (bus.req_ready != 4'b0000) begin
            for (int j = 0; j < 4; j++)
               if (bus.req_ready[j]) gid[ng] = j;
            gcyc[ng] = c;
            last     = gid[ng];
            ng++;
         end
         tick;
      end
      fpu_done      = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      n_tests++;
      if (ng != 6) begin
         n_fail++;
         $display("FAIL rr_grant_count: got %0d want 6 within budget", ng);
      end
      for (int k = 0; k < ng; k++) begin
         n_tests++;
         if (gid[k] != exp_g[k]) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got %0d want %0d",
                     k, gid[k], exp_g[k]);
         end
         if (k > 0) begin
            n_tests++;
            if (gcyc[k] - gcyc[k-1] != 4) begin
               n_fail++;
               $display("FAIL rr_interval[%0d]: got %0d want 4",
                        k, gcyc[k] - gcyc[k-1]);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      apply_reset;
      bus.req_op_a[63:32] = 32'h3F80_0000;
      bus.req_op_b[63:32] = 32'h3F80_0000;
      bus.req_valid       = 4'b0010;
      #1;
      n_tests++;
      if (bus.req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL bp_ready: got %b want 0010", bus.req_ready);
      end
      tick;
      bus.req_valid = '0;
      tick;
      fpu_done   = 1'b1;
      fpu_result = 32'h4000_0000;
      fpu_status = 4'b0010;
      tick;
      fpu_done      = 1'b0;
      bus.req_valid = 4'b1111;
      bus.rsp_ready = '0;
      for (int i = 0; i < 10; i++) begin
         n_tests++;
         if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.req_ready} !==
             {4'b0010, 32'h4000_0000, 4'b0010, 4'b0000}) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got %b %h %b %b want 0010 40000000 0010 0000",
                     i, bus.rsp_valid, bus.rsp_data, bus.rsp_status,
                     bus.req_ready);
         end
         fpu_done   = (i == 4);
         fpu_result = 32'hDEAD_BEEF;
         fpu_status = 4'b1000;
         tick;
      end
      fpu_done      = 1'b0;
      bus.rsp_ready = 4'b0010;
      tick;
      n_tests++;
      if (bus.req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL bp_next_pick: got %b want 0100", bus.req_ready);
      end
      bus.req_valid = '0;
      bus.rsp_ready = '0;
   endtask

   task automatic test_reset_mid;
      bus.req_op_a[127:96] = 32'h4040_0000;
      bus.req_op_b[127:96] = 32'h4040_0000;
      bus.req_valid        = 4'b1001;
      #1;
      n_tests++;
      if (bus.req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL rst_mid_pick: got %b want 1000", bus.req_ready);
      end
      tick;
      bus.req_valid = '0;
      tick;
      tick;
      n_tests++;
      if ({busy, grant_id} !== 3'b111) begin
         n_fail++;
         $display("FAIL rst_mid_wait: got busy=%b gid=%0d want 1 3",
                  busy, grant_id);
      end
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if ({busy, grant_id, fpu_op_a, bus.rsp_valid} !== 39'h0) begin
         n_fail++;
         $display("FAIL rst_mid_async: got %b %0d %h %b want 0 0 0 0000",
                  busy, grant_id, fpu_op_a, bus.rsp_valid);
      end
      tick;
      reset      = 1'b0;
      fpu_done   = 1'b1;
      fpu_result = 32'h1234_5678;
      fpu_status = 4'b0001;
      tick;
      fpu_done = 1'b0;
      tick;
      n_tests++;
      if ({busy, bus.rsp_valid, bus.rsp_data, bus.rsp_status} !== 41'h0) begin
         n_fail++;
         $display("FAIL rst_mid_late_done: got %b %b %h %b want 0 0000 0 0000",
                  busy, bus.rsp_valid, bus.rsp_data, bus.rsp_status);
      end
      bus.req_valid = 4'b1111;
      #1;
      n_tests++;
      if (bus.req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL rst_mid_rr_ptr: got %b want 0001", bus.req_ready);
      end
      bus.req_valid = '0;
   endtask

`ifdef FPU_ARB_TIMEOUT_EN
   task automatic test_timeout;
      apply_reset;
      bus.req_op_a[31:0] = 32'h7F00_0000;
      bus.req_op_b[31:0] = 32'h7F00_0000;
      bus.req_valid      = 4'b0001;
      tick;
      bus.req_valid = '0;
      for (int i = 0; i < 8; i++) tick;
      n_tests++;
      if (bus.rsp_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL to_race_early: got %b want 0000", bus.rsp_valid);
      end
      fpu_done   = 1'b1;
      fpu_result = 32'h7F80_0000;
      fpu_status = 4'b0100;
      tick;
      fpu_done = 1'b0;
      n_tests++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status} !==
          {4'b0001, 32'h7F80_0000, 4'b0100}) begin
         n_fail++;
         $display("FAIL to_race: got %b %h %b want 0001 7f800000 0100",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_status);
      end
      bus.rsp_ready = 4'b0001;
      tick;
      bus.rsp_ready = '0;
      bus.req_valid = 4'b0001;
      tick;
      bus.req_valid = '0;
      for (int i = 0; i < 8; i++) tick;
      n_tests++;
      if (bus.rsp_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL to_early: got %b want 0000", bus.rsp_valid);
      end
      tick;
      n_tests++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status} !==
          {4'b0001, 32'h0, 4'b0000}) begin
         n_fail++;
         $display("FAIL to_expire: got %b %h %b want 0001 0 0000",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_status);
      end
      bus.rsp_ready = 4'b0001;
      tick;
      bus.rsp_ready = '0;
   endtask
`endif

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_backpressure;
      test_reset_mid;
`ifdef FPU_ARB_TIMEOUT_EN
      test_timeout;
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
